// File: rtl/core_pkg.sv
// core_pkg: types and constants shared by the front-end fetch logic.
// Holds the default datapath width, the canonical NOP encoding and the
// layout of one fetch-queue entry.
package core_pkg;

    // Default datapath / address width.
    localparam int XLEN_DEFAULT = 32;

    // addi x0, x0, 0: injected in place of an instruction fetched from a bad target.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // One decoded-side queue entry: fetch address, instruction word, misalign flag.
    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [31:0]             instr;
        logic                    misalign;
    } fetch_entry_t;

    // Fetch sequencing state; HALT is only reachable when misalign checking is built in.
    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with circular read/write pointers and an
// occupancy count. Used for both the instruction queue and the PC FIFO that
// pairs in-order memory responses with the address that requested them.
// clear has priority over pop; a push in the same cycle as clear lands in
// entry 0 so the FIFO restarts holding exactly that one word.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] entries;
    logic [AW-1:0]               wr_ptr_reg;
    logic [AW-1:0]               rd_ptr_reg;
    logic [CW-1:0]               count_reg;
    logic                        push_ok;
    logic                        pop_ok;

    // A full FIFO refuses further pushes; an empty one ignores pops.
    assign push_ok = push & (clear | (count_reg != CW'(DEPTH)));
    assign pop_ok  = pop & ~clear & (count_reg != '0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            // Capture the pushed word in the slot the write pointer selects.
            always_ff @(posedge clock) begin
                if (reset) begin
                    entry_reg <= '0;
                end else if (push_ok && (clear ? (gi == 0) : (wr_ptr_reg == AW'(gi)))) begin
                    entry_reg <= push_data;
                end
            end

            assign entries[gi] = entry_reg;
        end
    endgenerate

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= push_ok ? AW'(1) : '0;
            rd_ptr_reg <= '0;
            count_reg  <= push_ok ? CW'(1) : '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = entries[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end. Issues word-aligned requests to an
// in-order instruction memory under a credit rule (queued + in-flight never
// exceeds FQ_DEPTH), pairs each response with its PC and queues it for decode.
// A redirect flushes everything and discards the responses still in flight.
// Optional build macro FETCH_MISALIGN_CHK_EN: a redirect to a non-word-aligned
// target halts fetch and hands decode a single NOP entry flagged d_misalign;
// without it the low two target bits are simply ignored.
module fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            br_en,
    input  logic [XLEN-1:0] br_addr,
    output logic            d_valid,
    input  logic            d_ready,
    output logic [XLEN-1:0] d_pc,
    output logic [31:0]     d_instr
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic            d_misalign
`endif
);

    localparam int              CW           = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW:0]     CREDIT_LIMIT = (CW + 1)'(FQ_DEPTH);
`ifdef FETCH_MISALIGN_CHK_EN
    localparam int              EW           = XLEN + 33;
`else
    localparam int              EW           = XLEN + 32;
`endif

    logic [XLEN-1:0] fetch_pc_reg;
    logic [CW-1:0]   outstanding_reg;
    logic [CW-1:0]   drop_cnt_reg;

    logic [CW-1:0]   q_count;
    logic [EW-1:0]   q_head;
    logic [EW-1:0]   q_push_data;
    logic            q_push;
    logic            q_pop;

    logic [CW-1:0]   pc_count;
    logic [XLEN-1:0] pc_head;

    logic [XLEN-1:0] br_target;
    logic            misalign_redirect;
    logic            halted;
    logic            credit_ok;
    logic            req_fire;
    logic            resp_live;

    // Fetch always restarts on a word boundary.
    assign br_target = br_addr & ~XLEN'(3);

`ifdef FETCH_MISALIGN_CHK_EN
    fetch_state_t state_reg;

    assign misalign_redirect = br_en & (br_addr[1:0] != 2'b00);
    assign halted            = (state_reg == FS_HALT);

    // Halt after a misaligned redirect; only another redirect resumes fetching.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= FS_RUN;
        end else if (br_en) begin
            state_reg <= misalign_redirect ? FS_HALT : FS_RUN;
        end
    end
`else
    assign misalign_redirect = 1'b0;
    assign halted            = 1'b0;
`endif

    // Credit: every in-flight request already owns a queue slot.
    assign credit_ok      = (({1'b0, q_count} + {1'b0, outstanding_reg}) < CREDIT_LIMIT);
    assign imem_req_valid = ~reset & ~br_en & ~halted & credit_ok;
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // A response is kept only if it belongs to a request issued after the last
    // redirect; the PC-FIFO occupancy check guards against a stray response.
    assign resp_live = imem_resp_valid & ~br_en & (drop_cnt_reg == '0) & (pc_count != '0);
    assign q_pop     = d_valid & d_ready & ~br_en;
    assign q_push    = resp_live | misalign_redirect;

`ifdef FETCH_MISALIGN_CHK_EN
    assign q_push_data = misalign_redirect ? {br_addr, NOP_INSTR, 1'b1}
                                           : {pc_head, imem_resp_data, 1'b0};
    assign {d_pc, d_instr, d_misalign} = q_head;
`else
    assign q_push_data = {pc_head, imem_resp_data};
    assign {d_pc, d_instr} = q_head;
`endif

    assign d_valid = (q_count != '0);

    // Fetch PC, in-flight request count and number of stale responses to discard.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_reg    <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            if (br_en) begin
                fetch_pc_reg <= br_target;
                // Everything in flight is stale; a response arriving right now is
                // dropped on the spot and therefore not counted again.
                drop_cnt_reg <= outstanding_reg - CW'(imem_resp_valid);
            end else begin
                if (req_fire) begin
                    fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
                end
                if (imem_resp_valid && (drop_cnt_reg != '0)) begin
                    drop_cnt_reg <= drop_cnt_reg - CW'(1);
                end
            end
            outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(imem_resp_valid);
        end
    end

    fetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (EW)
    ) u_instr_q (
        .clock     (clock),
        .reset     (reset),
        .clear     (br_en),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .rd_data   (q_head),
        .count     (q_count)
    );

    fetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (XLEN)
    ) u_pc_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (br_en),
        .push      (req_fire),
        .push_data (fetch_pc_reg),
        .pop       (resp_live),
        .rd_data   (pc_head),
        .count     (pc_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven bench for fetch_unit. A small memory
// model answers each fired request after a selectable latency with a word
// derived from its address. A second instance with RESET_PC near the top of
// the address space exercises PC wrap-around. Misaligned-redirect behaviour is
// checked according to whether FETCH_MISALIGN_CHK_EN is defined.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        br_en;
    logic [31:0] br_addr;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        d_misalign;
    logic        w_misalign;
`endif

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_resp_valid;
    logic [31:0] w_resp_addr;
    logic        w_d_valid;
    logic [31:0] w_d_pc;
    logic [31:0] w_d_instr;

    int errors = 0;
    int checks = 0;
    int lat    = 1;

    always #5 clock = ~clock;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .FQ_DEPTH(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .br_en           (br_en),
        .br_addr         (br_addr),
        .d_valid         (d_valid),
        .d_ready         (d_ready),
        .d_pc            (d_pc),
        .d_instr         (d_instr)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .d_misalign      (d_misalign)
`endif
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .FQ_DEPTH(4)) dut_w (
        .clock           (clock),
        .reset           (reset),
        .imem_req_valid  (w_req_valid),
        .imem_req_addr   (w_req_addr),
        .imem_req_ready  (1'b1),
        .imem_resp_valid (w_resp_valid),
        .imem_resp_data  (instr_of(w_resp_addr)),
        .br_en           (1'b0),
        .br_addr         (32'h0),
        .d_valid         (w_d_valid),
        .d_ready         (1'b1),
        .d_pc            (w_d_pc),
        .d_instr         (w_d_instr)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .d_misalign      (w_misalign)
`endif
    );

    // Main memory model: response returns lat cycles after the request fired.
    logic [3:0]  pipe_v;
    logic [31:0] pipe_a [4];
    always @(posedge clock) begin
        if (reset) pipe_v <= '0;
        else       pipe_v <= {pipe_v[2:0], imem_req_valid & imem_req_ready};
        pipe_a[0] <= imem_req_addr;
        pipe_a[1] <= pipe_a[0];
        pipe_a[2] <= pipe_a[1];
        pipe_a[3] <= pipe_a[2];
    end
    assign imem_resp_valid = pipe_v[lat-1];
    assign imem_resp_data  = instr_of(pipe_a[lat-1]);

    // Wrap-instance memory: fixed one-cycle latency, always ready.
    always @(posedge clock) begin
        if (reset) w_resp_valid <= 1'b0;
        else       w_resp_valid <= w_req_valid;
        w_resp_addr <= w_req_addr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        br_en;
        logic [31:0] br_addr;
        logic        d_ready;
        logic        exp_rv;
        logic [31:0] exp_ra;
        logic        exp_dv;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input logic b, input logic [31:0] ba, input logic dr,
                                 input logic rv, input logic [31:0] ra,
                                 input logic dv, input logic [31:0] pc);
        vec_t r;
        r.br_en = b; r.br_addr = ba; r.d_ready = dr;
        r.exp_rv = rv; r.exp_ra = ra; r.exp_dv = dv; r.exp_pc = pc;
        return r;
    endfunction

    // Reset both instances and the memories; check the reset-state outputs.
    task automatic do_reset(input int new_lat);
        @(negedge clock);
        reset = 1'b1; br_en = 1'b0; br_addr = '0; d_ready = 1'b1; lat = new_lat;
        repeat (2) @(negedge clock);
        chk("rst.req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst.req_addr",  imem_req_addr,       32'h0);
        chk("rst.d_valid",   32'(d_valid),        32'h0);
        chk("rst.d_pc",      d_pc,                32'h0);
        chk("rst.d_instr",   d_instr,             32'h0);
        chk("rst.w_addr",    w_req_addr,          32'hFFFF_FFFC);
        chk("rst.w_d_valid", 32'(w_d_valid),      32'h0);
        reset = 1'b0;
    endtask

    // Apply one vector per cycle, starting at the current negedge.
    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            br_en = tbl[i].br_en; br_addr = tbl[i].br_addr; d_ready = tbl[i].d_ready;
            #1;
            $display("%s[%0d] br=%b/%h rdy=%b req=%b/%h d=%b/%h/%h", tag, i, br_en, br_addr,
                     d_ready, imem_req_valid, imem_req_addr, d_valid, d_pc, d_instr);
            chk($sformatf("%s[%0d].req_valid", tag, i), 32'(imem_req_valid), 32'(tbl[i].exp_rv));
            chk($sformatf("%s[%0d].req_addr", tag, i), imem_req_addr, tbl[i].exp_ra);
            chk($sformatf("%s[%0d].d_valid", tag, i), 32'(d_valid), 32'(tbl[i].exp_dv));
            if (tbl[i].exp_dv) begin
                chk($sformatf("%s[%0d].d_pc", tag, i), d_pc, tbl[i].exp_pc);
                chk($sformatf("%s[%0d].d_instr", tag, i), d_instr, instr_of(tbl[i].exp_pc));
            end
            @(negedge clock);
        end
        br_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; br_en = 1'b0; br_addr = '0; d_ready = 1'b1; imem_req_ready = 1'b1;

        // PC wrap from RESET_PC = 0xFFFF_FFFC.
        do_reset(1);
        #1;
        chk("wrap.c0.req", w_req_addr, 32'hFFFF_FFFC);
        @(negedge clock); #1;
        chk("wrap.c1.req", w_req_addr, 32'h0000_0000);
        @(negedge clock); #1;
        $display("wrap c2 d=%b/%h/%h", w_d_valid, w_d_pc, w_d_instr);
        chk("wrap.c2.d_valid", 32'(w_d_valid), 32'h1);
        chk("wrap.c2.d_pc",    w_d_pc,         32'hFFFF_FFFC);
        chk("wrap.c2.d_instr", w_d_instr,      instr_of(32'hFFFF_FFFC));
        @(negedge clock); #1;
        $display("wrap c3 d=%b/%h/%h", w_d_valid, w_d_pc, w_d_instr);
        chk("wrap.c3.d_pc",    w_d_pc,         32'h0000_0000);
        chk("wrap.c3.d_instr", w_d_instr,      instr_of(32'h0000_0000));

        // Streaming, decode stall to full credit, then redirect with response+pop.
        do_reset(1);
        tbl.delete();
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h00,  1'b0, 32'h0));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h04,  1'b0, 32'h0));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h08,  1'b1, 32'h00));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h0C,  1'b1, 32'h04));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'h08));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b0, 1'b1, 32'h14,  1'b1, 32'h0C));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b0, 1'b1, 32'h18,  1'b1, 32'h0C));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b0, 1'b0, 32'h1C,  1'b1, 32'h0C));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b0, 1'b0, 32'h1C,  1'b1, 32'h0C));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b0, 1'b0, 32'h1C,  1'b1, 32'h0C));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b0, 32'h1C,  1'b1, 32'h0C));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h1C,  1'b1, 32'h10));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h20,  1'b1, 32'h14));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h24,  1'b1, 32'h18));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h28,  1'b1, 32'h1C));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h2C,  1'b1, 32'h20));
        tbl.push_back(mkv(1'b1, 32'h100, 1'b1, 1'b0, 32'h30,  1'b1, 32'h24));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, 32'h0));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 1'b1, 32'h100));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h10C, 1'b1, 32'h104));
        run_table("stream");

        // Redirect with two requests in flight (latency 3): both responses dropped.
        do_reset(3);
        tbl.delete();
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h00,  1'b0, 32'h0));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h04,  1'b0, 32'h0));
        tbl.push_back(mkv(1'b1, 32'h100, 1'b1, 1'b0, 32'h08,  1'b0, 32'h0));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, 32'h0));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 1'b0, 32'h0));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h10C, 1'b0, 32'h0));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b0, 32'h110, 1'b1, 32'h100));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h110, 1'b1, 32'h104));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h114, 1'b1, 32'h108));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h118, 1'b1, 32'h10C));
        run_table("drop2");

        // Back-to-back redirects: second one recomputes the drop count.
        do_reset(3);
        tbl.delete();
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h00,  1'b0, 32'h0));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h04,  1'b0, 32'h0));
        tbl.push_back(mkv(1'b1, 32'h100, 1'b1, 1'b0, 32'h08,  1'b0, 32'h0));
        tbl.push_back(mkv(1'b1, 32'h200, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h0));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 1'b0, 32'h0));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h208, 1'b0, 32'h0));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h20C, 1'b0, 32'h0));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b0, 32'h210, 1'b1, 32'h200));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h210, 1'b1, 32'h204));
        run_table("b2b");

        do_reset(1);
`ifdef FETCH_MISALIGN_CHK_EN
        // Misaligned redirect: one NOP entry flagged, fetch halted until next redirect.
        #1;
        chk("mis.c0.req_valid", 32'(imem_req_valid), 32'h1);
        @(negedge clock);
        br_en = 1'b1; br_addr = 32'h102; #1;
        chk("mis.c1.req_valid", 32'(imem_req_valid), 32'h0);
        @(negedge clock);
        br_en = 1'b0; #1;
        $display("mis c2 d=%b/%h/%h/%b req=%b", d_valid, d_pc, d_instr, d_misalign, imem_req_valid);
        chk("mis.c2.d_valid",   32'(d_valid),        32'h1);
        chk("mis.c2.d_pc",      d_pc,                32'h102);
        chk("mis.c2.d_instr",   d_instr,             32'h0000_0013);
        chk("mis.c2.misalign",  32'(d_misalign),     32'h1);
        chk("mis.c2.req_valid", 32'(imem_req_valid), 32'h0);
        @(negedge clock); #1;
        chk("mis.c3.d_valid",   32'(d_valid),        32'h0);
        chk("mis.c3.req_valid", 32'(imem_req_valid), 32'h0);
        @(negedge clock); #1;
        chk("mis.c4.req_valid", 32'(imem_req_valid), 32'h0);
        @(negedge clock);
        br_en = 1'b1; br_addr = 32'h200; #1;
        chk("mis.c5.req_valid", 32'(imem_req_valid), 32'h0);
        @(negedge clock);
        br_en = 1'b0; #1;
        $display("mis c6 req=%b/%h", imem_req_valid, imem_req_addr);
        chk("mis.c6.req_valid", 32'(imem_req_valid), 32'h1);
        chk("mis.c6.req_addr",  imem_req_addr,       32'h200);
        @(negedge clock); @(negedge clock); #1;
        chk("mis.c8.misalign",  32'(d_misalign),     32'h0);
        chk("mis.c8.d_pc",      d_pc,                32'h200);
`else
        // Misaligned target bits are ignored: fetch resumes at the aligned word.
        tbl.delete();
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h000, 1'b0, 32'h0));
        tbl.push_back(mkv(1'b1, 32'h106, 1'b1, 1'b0, 32'h004, 1'b0, 32'h0));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, 32'h0));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 1'b0, 32'h0));
        tbl.push_back(mkv(1'b0, 32'h0,   1'b1, 1'b1, 32'h10C, 1'b1, 32'h104));
        run_table("align");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath/address width in bits.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter FQ_DEPTH, default 4, fetch-queue entries; power of 2, 2..16.
REQ-004 clock  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 imem_req_valid  out  1  fetch request valid.
REQ-007 imem_req_addr  out  XLEN  fetch address, word aligned.
REQ-008 imem_req_ready  in  1  memory accepts request this cycle.
REQ-009 imem_resp_valid  in  1  in-order response valid; always accepted.
REQ-010 imem_resp_data  in  32  instruction word.
REQ-011 br_en  in  1  redirect request from execute.
REQ-012 br_addr  in  XLEN  redirect target.
REQ-013 d_valid  out  1  queue head valid to decode.
REQ-014 d_ready  in  1  decode accepts head.
REQ-015 d_pc  out  XLEN  PC of head entry.
REQ-016 d_instr  out  32  instruction of head entry.

Function
REQ-017 Request fires when imem_req_valid & imem_req_ready; fetch PC then advances by 4.
REQ-018 imem_req_valid SHALL be high only if count + outstanding < FQ_DEPTH (credit rule); queue never overflows.
REQ-019 outstanding SHALL increment on each fired request and decrement on each response; both in one cycle leaves it unchanged.
REQ-020 Each accepted, non-dropped response SHALL be pushed with its request PC, from a PC FIFO holding up to FQ_DEPTH entries.
REQ-021 d_valid = queue non-empty; head pops on d_valid & d_ready; push and pop in the same cycle keep count unchanged.
REQ-022 Data latency: response in cycle N -> d_valid in cycle N+1 (registered queue, no bypass).
REQ-023 Redirect (br_en=1) has priority: queue and PC FIFO cleared, fetch PC <= br_addr, imem_req_valid forced 0 that cycle, pop ignored.
REQ-024 On redirect, drop_cnt <= outstanding minus 1 if a response arrives that cycle; responses arriving while drop_cnt>0 are discarded and decrement drop_cnt.
REQ-025 Requests after a redirect MAY issue while drop_cnt>0; outstanding counts dropped and live requests alike.
REQ-026 Fetch PC wraps modulo 2^XLEN without error.
REQ-027 Back-to-back redirects: the last one wins, drop_cnt recomputed from current outstanding.

Reset
REQ-028 On reset: fetch PC = RESET_PC, queue empty, outstanding = 0, drop_cnt = 0, d_valid = 0, imem_req_valid = 0, d_pc/d_instr = 0.
REQ-029 Reset mid-operation SHALL abandon in-flight responses; the memory is reset by the same signal.
REQ-030 First request SHALL issue the cycle after reset deasserts.

Configuration
REQ-031 Macro FETCH_MISALIGN_CHK_EN: when defined, a redirect with br_addr[1:0] != 0 halts fetching and enqueues one entry with d_instr = NOP 32'h0000_0013 and an extra output d_misalign = 1; fetching stays halted until the next redirect.
REQ-032 Without FETCH_MISALIGN_CHK_EN: the d_misalign port is absent and br_addr[1:0] is ignored (forced to 0).

Structure
REQ-033 Shared package core_pkg SHALL hold XLEN default, NOP_INSTR constant and the fetch_entry_t typedef (pc, instr, misalign).
REQ-034 A single sub-module fetch_fifo (parametrised depth/width, circular pointers, count) SHALL implement the instruction queue and the PC FIFO.

Verification
REQ-035 Reset, imem always ready, 1-cycle response, d_ready=1 -> d_pc sequence 0,4,8,12..., one instruction per cycle after fill.
REQ-036 d_ready=0, FQ_DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0, count=4, no lost data.
REQ-037 2 outstanding requests, br_en=1 with br_addr=0x100 -> both responses dropped, next d_pc=0x100.
REQ-038 Redirect in the same cycle as a response and a pop -> response dropped, queue empty next cycle, drop_cnt = outstanding-1.
REQ-039 FETCH_MISALIGN_CHK_EN defined, br_addr=0x102 -> one entry d_instr=0x00000013, d_misalign=1, then no requests until redirect 0x200.
REQ-040 RESET_PC=0xFFFF_FFFC -> d_pc sequence 0xFFFF_FFFC then 0x0000_0000.
